// File: rtl/i2c_poll_sequencer.sv
// rtl/i2c_poll_sequencer.sv - polling command sequencer in front of i2c_master (optional init write: I2C_SEQ_INIT_EN)
module i2c_poll_sequencer #(
    parameter logic [6:0]  DEV_ADDR   = 7'h48,
    parameter logic [7:0]  REG_PTR    = 8'h00,
    parameter int          READ_BYTES = 2,
    parameter logic [31:0] INIT_DATA  = 32'h0000_0160,
    parameter int          INIT_BYTES = 2,
    parameter int          POLL_DIV   = 1000000,
    parameter int          TIMEOUT    = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        i2c_start,
    input  logic        i2c_busy,
    output logic [6:0]  i2c_addr,
    output logic        i2c_rw,
    output logic [4:0]  i2c_bytes,
    output logic [31:0] i2c_data_out,
    input  logic [31:0] i2c_data_in,
    input  logic        i2c_valid,
    output logic [31:0] value,
    output logic        value_strobe,
    output logic        nack,
    output logic [7:0]  err_count
);

    // Each REQ state is immediately followed by its WAIT state (REQ + 1)
    localparam logic [2:0] S_IDLE      = 3'd0;
`ifdef I2C_SEQ_INIT_EN
    localparam logic [2:0] S_INIT_REQ  = 3'd1;
    localparam logic [2:0] S_INIT_WAIT = 3'd2;
    localparam logic [4:0] INIT_LEN    = 5'(INIT_BYTES);
`endif
    localparam logic [2:0] S_PTR_REQ   = 3'd3;
    localparam logic [2:0] S_PTR_WAIT  = 3'd4;
    localparam logic [2:0] S_RD_REQ    = 3'd5;
    localparam logic [2:0] S_RD_WAIT   = 3'd6;
    localparam logic [2:0] S_HOLD      = 3'd7;

    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [31:0] POLL_LAST = 32'(POLL_DIV - 1);
    localparam logic [4:0]  RD_LEN    = 5'(READ_BYTES);
    localparam logic [31:0] RD_MASK   = (READ_BYTES >= 4) ? 32'hFFFF_FFFF :
                                        32'((64'd1 << (8 * READ_BYTES)) - 64'd1);
    localparam logic [31:0] PTR_WORD  = {24'h0, REG_PTR};

    logic [2:0]  r_state;
    logic [31:0] r_cnt;
    logic        r_busy_meta, r_busy_s;
    logic        r_valid_meta, r_valid_s;
    logic        r_start, r_rw, r_strobe, r_nack;
    logic [4:0]  r_bytes;
    logic [31:0] r_data_out, r_value;
    logic [7:0]  r_err;
    logic        w_tmo;
    logic [7:0]  w_err_next;
`ifdef I2C_SEQ_INIT_EN
    logic        r_init_pend;
`else
    logic        w_unused_init;
    assign w_unused_init = ^INIT_DATA ^ (INIT_BYTES != 0);
`endif

    assign w_tmo      = (r_cnt >= TMO_LAST);
    assign w_err_next = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

    // Synchronize master status; busy resets high so a master still busy across reset is never re-issued to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_meta  <= 1'b1;
            r_busy_s     <= 1'b1;
            r_valid_meta <= 1'b0;
            r_valid_s    <= 1'b0;
        end else begin
            r_busy_meta  <= i2c_busy;
            r_busy_s     <= r_busy_meta;
            r_valid_meta <= i2c_valid;
            r_valid_s    <= r_valid_meta;
        end
    end

    // Sequencer FSM: request fields are loaded on the edge entering REQ, start rises one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_start    <= 1'b0;
            r_rw       <= 1'b0;
            r_bytes    <= '0;
            r_data_out <= '0;
            r_value    <= '0;
            r_strobe   <= 1'b0;
            r_nack     <= 1'b0;
            r_err      <= '0;
`ifdef I2C_SEQ_INIT_EN
            r_init_pend <= 1'b1;
`endif
        end else begin
            r_strobe <= 1'b0;
            r_cnt    <= r_cnt + 32'd1;
            case (r_state)
                S_IDLE: begin
                    r_start <= 1'b0;
                    if (enable && !r_busy_s) begin
                        r_cnt <= '0;
                        r_rw  <= 1'b0;
`ifdef I2C_SEQ_INIT_EN
                        if (r_init_pend) begin
                            r_init_pend <= 1'b0;
                            r_bytes     <= INIT_LEN;
                            r_data_out  <= INIT_DATA;
                            r_state     <= S_INIT_REQ;
                        end else begin
                            r_bytes    <= 5'd1;
                            r_data_out <= PTR_WORD;
                            r_state    <= S_PTR_REQ;
                        end
`else
                        r_bytes    <= 5'd1;
                        r_data_out <= PTR_WORD;
                        r_state    <= S_PTR_REQ;
`endif
                    end
                end
`ifdef I2C_SEQ_INIT_EN
                S_INIT_REQ,
`endif
                S_PTR_REQ, S_RD_REQ: begin
                    if (r_busy_s) begin
                        r_start <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= r_state + 3'd1;
                    end else if (w_tmo) begin
                        r_start <= 1'b0;
                        r_cnt   <= '0;
                        r_err   <= w_err_next;
                        r_state <= S_HOLD;
                    end else begin
                        r_start <= 1'b1;
                    end
                end
`ifdef I2C_SEQ_INIT_EN
                S_INIT_WAIT: begin
                    if (!r_busy_s) begin
                        r_cnt      <= '0;
                        r_bytes    <= 5'd1;
                        r_data_out <= PTR_WORD;
                        r_state    <= S_PTR_REQ;
                    end else if (w_tmo) begin
                        r_cnt   <= '0;
                        r_err   <= w_err_next;
                        r_state <= S_HOLD;
                    end
                end
`endif
                S_PTR_WAIT: begin
                    if (!r_busy_s) begin
                        r_cnt   <= '0;
                        r_rw    <= 1'b1;
                        r_bytes <= RD_LEN;
                        r_state <= S_RD_REQ;
                    end else if (w_tmo) begin
                        r_cnt   <= '0;
                        r_err   <= w_err_next;
                        r_state <= S_HOLD;
                    end
                end
                S_RD_WAIT: begin
                    if (!r_busy_s) begin
                        r_cnt   <= '0;
                        r_state <= S_HOLD;
                        if (r_valid_s) begin
                            r_value  <= i2c_data_in & RD_MASK;
                            r_strobe <= 1'b1;
                            r_nack   <= 1'b0;
                        end else begin
                            r_nack <= 1'b1;
                            r_err  <= w_err_next;
                        end
                    end else if (w_tmo) begin
                        r_cnt   <= '0;
                        r_err   <= w_err_next;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!enable || (r_cnt >= POLL_LAST)) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_start <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign i2c_start    = r_start;
    assign i2c_addr     = DEV_ADDR;
    assign i2c_rw       = r_rw;
    assign i2c_bytes    = r_bytes;
    assign i2c_data_out = r_data_out;
    assign value        = r_value;
    assign value_strobe = r_strobe;
    assign nack         = r_nack;
    assign err_count    = r_err;

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// tb/tb_i2c_poll_sequencer.sv - directed bench for i2c_poll_sequencer with a behavioural i2c_master model
module tb_i2c_poll_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, enable2 = 1'b0, enable4 = 1'b0, sel = 1'b0;
    logic        start2, start4, rw2, rw4, strobe2, strobe4, nack2, nack4;
    logic [6:0]  addr2, addr4;
    logic [4:0]  bytes2, bytes4;
    logic [31:0] dout2, dout4, value2, value4;
    logic [7:0]  err2, err4;
    logic        m_busy = 1'b0, f_busy = 1'b0, m_valid = 1'b0, busy_w;
    logic [31:0] m_data_in = '0;
    assign busy_w = m_busy | f_busy;

    i2c_poll_sequencer #(.POLL_DIV(50), .TIMEOUT(200)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable2), .i2c_start(start2), .i2c_busy(busy_w),
        .i2c_addr(addr2), .i2c_rw(rw2), .i2c_bytes(bytes2), .i2c_data_out(dout2),
        .i2c_data_in(m_data_in), .i2c_valid(m_valid), .value(value2), .value_strobe(strobe2),
        .nack(nack2), .err_count(err2));

    i2c_poll_sequencer #(.READ_BYTES(4), .POLL_DIV(50), .TIMEOUT(200)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable4), .i2c_start(start4), .i2c_busy(busy_w),
        .i2c_addr(addr4), .i2c_rw(rw4), .i2c_bytes(bytes4), .i2c_data_out(dout4),
        .i2c_data_in(m_data_in), .i2c_valid(m_valid), .value(value4), .value_strobe(strobe4),
        .nack(nack4), .err_count(err4));

    // the master model serves whichever instance sel points at
    logic        w_start, w_strobe;
    logic [37:0] w_req;
    assign w_start  = sel ? start4 : start2;
    assign w_strobe = sel ? strobe4 : strobe2;
    assign w_req    = sel ? {rw4, bytes4, dout4} : {rw2, bytes2, dout2};

    int          n_vec = 0, n_err = 0;
    logic        m_ignore = 1'b0, m_give_valid = 1'b1, m_in_read = 1'b0;
    logic [31:0] m_rdata = '0;
    int          n_reads = 0, stab_err = 0;
    logic [37:0] q_txn[$];

    // behavioural master: busy 3..20 clks after start, held 8 clks, result published as busy drops
    initial begin
        logic [37:0] cap;
        int lat;
        forever begin
            @(posedge clk); #1;
            if (w_start && !m_ignore && rst_n) begin
                cap = w_req;
                lat = $urandom_range(3, 20);
                repeat (lat) @(posedge clk);
                #1;
                m_valid = 1'b0; m_busy = 1'b1; m_in_read = cap[37];
                q_txn.push_back(cap);
                repeat (8) @(posedge clk);
                #1;
                if (w_req !== cap) stab_err++;
                m_data_in = m_rdata;
                if (cap[37] && m_give_valid) m_valid = 1'b1;
                m_busy = 1'b0; m_in_read = 1'b0;
                if (cap[37]) n_reads++;
            end
        end
    end

    int          strobe_cycles = 0, start_rises = 0, high_run = 0, low_run = 0;
    int          last_high = 0, last_low = 0, n_long = 0;
    logic        start_d = 1'b0;
    logic [37:0] prev_req = '0;

    // observe start/strobe activity away from the active edge
    always @(negedge clk) begin
        if (w_strobe) strobe_cycles++;
        if (w_start) begin
            if (!start_d) begin
                start_rises++;
                last_low = low_run;
                if (w_req !== prev_req) stab_err++;
            end
            high_run++; low_run = 0;
        end else begin
            if (start_d) begin
                last_high = high_run;
                if (high_run >= 100) n_long++;
            end
            high_run = 0; low_run++;
        end
        start_d  = w_start;
        prev_req = w_req;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (start2 !== 1'b0)  begin n_err++; $display("FAIL reset_start got=%0b exp=0", start2); end
        n_vec++; if (rw2 !== 1'b0)     begin n_err++; $display("FAIL reset_rw got=%0b exp=0", rw2); end
        n_vec++; if (bytes2 !== 5'd0)  begin n_err++; $display("FAIL reset_bytes got=%0d exp=0", bytes2); end
        n_vec++; if (dout2 !== 32'd0)  begin n_err++; $display("FAIL reset_data_out got=%h exp=0", dout2); end
        n_vec++; if (value2 !== 32'd0) begin n_err++; $display("FAIL reset_value got=%h exp=0", value2); end
        n_vec++; if (strobe2 !== 1'b0) begin n_err++; $display("FAIL reset_strobe got=%0b exp=0", strobe2); end
        n_vec++; if (nack2 !== 1'b0)   begin n_err++; $display("FAIL reset_nack got=%0b exp=0", nack2); end
        n_vec++; if (err2 !== 8'd0)    begin n_err++; $display("FAIL reset_err got=%0d exp=0", err2); end
        n_vec++; if (addr2 !== 7'h48)  begin n_err++; $display("FAIL reset_addr got=%h exp=48", addr2); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_first_sequence();
        int s0, idx;
        m_rdata = 32'h1234ABCD; m_give_valid = 1'b1;
        s0 = strobe_cycles;
        enable2 = 1'b1;
        for (int i = 0; i < 2000 && strobe_cycles == s0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_vec++; if (strobe_cycles !== s0 + 1) begin n_err++; $display("FAIL first_strobe_cycles got=%0d exp=%0d", strobe_cycles - s0, 1); end
        n_vec++; if (value2 !== 32'h0000ABCD) begin n_err++; $display("FAIL first_value got=%h exp=0000abcd", value2); end
        n_vec++; if (nack2 !== 1'b0 || err2 !== 8'd0) begin n_err++; $display("FAIL first_status got nack=%0b err=%0d exp 0/0", nack2, err2); end
        idx = 0;
`ifdef I2C_SEQ_INIT_EN
        idx = 1;
        n_vec++; if (q_txn.size() < 1 || q_txn[0] !== {1'b0, 5'd2, 32'h0000_0160}) begin n_err++; $display("FAIL first_init_txn got=%h exp=%h", (q_txn.size() > 0) ? q_txn[0] : 38'h0, {1'b0, 5'd2, 32'h0000_0160}); end
`endif
        n_vec++; if (q_txn.size() < idx + 2) begin n_err++; $display("FAIL first_txn_count got=%0d exp=%0d", q_txn.size(), idx + 2); end
        else begin
            n_vec++; if (q_txn[idx] !== {1'b0, 5'd1, 32'h0}) begin n_err++; $display("FAIL first_ptr_txn got=%h exp=%h", q_txn[idx], {1'b0, 5'd1, 32'h0}); end
            n_vec++; if (q_txn[idx + 1][37:32] !== {1'b1, 5'd2}) begin n_err++; $display("FAIL first_read_txn got rw/bytes=%h exp=%h", q_txn[idx + 1][37:32], {1'b1, 5'd2}); end
        end
    endtask

    task automatic test_nack();
        int r0, s0;
        m_give_valid = 1'b0;
        r0 = n_reads; s0 = strobe_cycles;
        for (int i = 0; i < 1000 && n_reads == r0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_vec++; if (nack2 !== 1'b1)  begin n_err++; $display("FAIL nack_flag got=%0b exp=1", nack2); end
        n_vec++; if (err2 !== 8'd1)   begin n_err++; $display("FAIL nack_err got=%0d exp=1", err2); end
        n_vec++; if (value2 !== 32'h0000ABCD || strobe_cycles !== s0) begin n_err++; $display("FAIL nack_value got=%h strobes=%0d exp=0000abcd 0", value2, strobe_cycles - s0); end
        m_give_valid = 1'b1; m_rdata = 32'h0000_5555;
        s0 = strobe_cycles;
        for (int i = 0; i < 1000 && strobe_cycles == s0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_vec++; if (nack2 !== 1'b0)  begin n_err++; $display("FAIL nack_clear got=%0b exp=0", nack2); end
        n_vec++; if (value2 !== 32'h0000_5555) begin n_err++; $display("FAIL nack_recover_value got=%h exp=00005555", value2); end
        n_vec++; if (err2 !== 8'd1)   begin n_err++; $display("FAIL nack_err_hold got=%0d exp=1", err2); end
    endtask

    task automatic test_timeout();
        int nl, r0;
        m_ignore = 1'b1;
        nl = n_long;
        for (int i = 0; i < 600 && n_long == nl; i++) @(negedge clk);
        n_vec++; if (n_long == nl || last_high < 190 || last_high > 210) begin n_err++; $display("FAIL timeout_start_len got=%0d exp=~200", last_high); end
        repeat (2) @(negedge clk);
        n_vec++; if (err2 !== 8'd2)   begin n_err++; $display("FAIL timeout_err got=%0d exp=2", err2); end
        r0 = start_rises;
        for (int i = 0; i < 200 && start_rises == r0; i++) @(negedge clk);
        n_vec++; if (start_rises == r0 || last_low < 50 || last_low > 56) begin n_err++; $display("FAIL timeout_retry_gap got=%0d exp=50..56", last_low); end
        for (int i = 0; i < 70000 && n_long < nl + 259; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_vec++; if (err2 !== 8'hFF)  begin n_err++; $display("FAIL timeout_saturate got=%0d exp=255 (timeouts=%0d)", err2, n_long - nl); end
        m_ignore = 1'b0;
    endtask

    task automatic test_enable_drop();
        int s0, r0;
        m_rdata = 32'h0000_BEEF; m_give_valid = 1'b1;
        for (int i = 0; i < 2000 && !m_in_read; i++) @(negedge clk);
        n_vec++; if (!m_in_read) begin n_err++; $display("FAIL drop_reach_read got=0 exp=1"); end
        s0 = strobe_cycles;
        enable2 = 1'b0;
        for (int i = 0; i < 200 && strobe_cycles == s0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_vec++; if (value2 !== 32'h0000_BEEF) begin n_err++; $display("FAIL drop_value got=%h exp=0000beef", value2); end
        r0 = start_rises;
        repeat (300) @(negedge clk);
        n_vec++; if (start_rises !== r0 || start2 !== 1'b0) begin n_err++; $display("FAIL drop_parked got rises=%0d start=%0b exp 0/0", start_rises - r0, start2); end
    endtask

    task automatic test_reset_busy();
        int k, r0;
        f_busy = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; enable2 = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if ({start2, rw2, bytes2, dout2} !== 39'd0) begin n_err++; $display("FAIL rstbusy_req got=%h exp=0", {start2, rw2, bytes2, dout2}); end
        n_vec++; if ({value2, strobe2, nack2, err2} !== 42'd0) begin n_err++; $display("FAIL rstbusy_status got=%h exp=0", {value2, strobe2, nack2, err2}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        r0 = start_rises;
        repeat (30) @(negedge clk);
        n_vec++; if (start_rises !== r0) begin n_err++; $display("FAIL rstbusy_no_start got=%0d exp=0", start_rises - r0); end
        q_txn.delete();
        @(posedge clk); #1;
        f_busy = 1'b0;
        k = 0;
        while (k < 20 && !start2) begin
            @(posedge clk); #1;
            k++;
        end
        n_vec++; if (k !== 4) begin n_err++; $display("FAIL rstbusy_start_delay got=%0d exp=4", k); end
        for (int i = 0; i < 100 && q_txn.size() == 0; i++) @(negedge clk);
`ifdef I2C_SEQ_INIT_EN
        n_vec++; if (q_txn.size() == 0 || q_txn[0] !== {1'b0, 5'd2, 32'h0000_0160}) begin n_err++; $display("FAIL rstbusy_first_txn got=%h exp=%h", (q_txn.size() > 0) ? q_txn[0] : 38'h0, {1'b0, 5'd2, 32'h0000_0160}); end
`else
        n_vec++; if (q_txn.size() == 0 || q_txn[0] !== {1'b0, 5'd1, 32'h0}) begin n_err++; $display("FAIL rstbusy_first_txn got=%h exp=%h", (q_txn.size() > 0) ? q_txn[0] : 38'h0, {1'b0, 5'd1, 32'h0}); end
`endif
    endtask

    task automatic test_read4();
        int s0, idx;
        enable2 = 1'b0;
        repeat (500) @(negedge clk);
        n_vec++; if (start2 !== 1'b0 || m_busy !== 1'b0) begin n_err++; $display("FAIL read4_dut2_parked got start=%0b busy=%0b exp 0/0", start2, m_busy); end
        sel = 1'b1;
        q_txn.delete();
        m_rdata = 32'hDEAD_BEEF; m_give_valid = 1'b1;
        s0 = strobe_cycles;
        enable4 = 1'b1;
        for (int i = 0; i < 2000 && strobe_cycles == s0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_vec++; if (value4 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL read4_value got=%h exp=deadbeef", value4); end
        n_vec++; if (nack4 !== 1'b0 || err4 !== 8'd0) begin n_err++; $display("FAIL read4_status got nack=%0b err=%0d exp 0/0", nack4, err4); end
        idx = 0;
`ifdef I2C_SEQ_INIT_EN
        idx = 1;
`endif
        n_vec++; if (q_txn.size() < idx + 2) begin n_err++; $display("FAIL read4_txn_count got=%0d exp=%0d", q_txn.size(), idx + 2); end
        else begin
            n_vec++; if (q_txn[idx] !== {1'b0, 5'd1, 32'h0}) begin n_err++; $display("FAIL read4_ptr_txn got=%h exp=%h", q_txn[idx], {1'b0, 5'd1, 32'h0}); end
            n_vec++; if (q_txn[idx + 1][37:32] !== {1'b1, 5'd4}) begin n_err++; $display("FAIL read4_read_txn got=%h exp=%h", q_txn[idx + 1][37:32], {1'b1, 5'd4}); end
        end
        n_vec++; if (stab_err !== 0) begin n_err++; $display("FAIL request_stability got=%0d exp=0", stab_err); end
    endtask

    initial begin
        test_reset();
        test_first_sequence();
        test_nack();
        test_timeout();
        test_enable_drop();
        test_reset_busy();
        test_read4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
